divider_unit: RTL and testbench
===============================

DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, 32, operand/result width in bits; only 32 is verified.
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port reset SHALL be: reset  input  1  asynchronous, active-high reset.
REQ-004 Port start SHALL be: start  input  1  execute-stage request; the operation is an M-extension divide.
REQ-005 Port funct3 SHALL be: funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port srcA SHALL be: srcA  input  WIDTH  dividend.
REQ-007 Port srcB SHALL be: srcB  input  WIDTH  divisor.
REQ-008 Port flush SHALL be: flush  input  1  execute-stage flush; aborts any operation.
REQ-009 Port result SHALL be: result  output  WIDTH  quotient or remainder, registered.
REQ-010 Port done SHALL be: done  output  1  one-cycle pulse; result is valid in this cycle.
REQ-011 Port busy SHALL be: busy  output  1  stall request to the hazard unit.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 A start in IDLE with funct3[2]=1 and flush=0 SHALL be accepted; srcA, srcB and funct3 SHALL be latched on that edge.
REQ-014 The block SHALL ignore start when funct3[2]=0, and SHALL ignore start in CALC or DONE.
REQ-015 Divide-by-zero (srcB=0) SHALL go IDLE->DONE with quotient all-ones and remainder equal to srcA.
REQ-016 Signed overflow (DIV/REM, srcA=0x80000000, srcB=0xFFFFFFFF) SHALL go IDLE->DONE with quotient 0x80000000 and remainder 0.
REQ-017 Other accepted requests SHALL go IDLE->CALC, operating on magnitudes: absolute values for DIV/REM, raw values for DIVU/REMU.
REQ-018 CALC SHALL perform one restoring step per cycle for exactly WIDTH cycles, counted by a 6-bit iteration counter, then go to DONE.
REQ-019 On the final step, the quotient SHALL be negated for DIV when the operand signs differ, and the remainder SHALL be negated for REM when srcA is negative.
REQ-020 In DONE, done=1 and result SHALL hold the quotient (DIV/DIVU) or the remainder (REM/REMU); the next state SHALL be IDLE.
REQ-021 Latency SHALL be: start accepted at edge T, done high in the cycle after edge T+WIDTH+1 (normal) or after edge T+1 (special cases).
REQ-022 busy SHALL be combinational: (state==CALC) OR (state==IDLE AND start accepted AND not a special case); busy SHALL be low in DONE.
REQ-023 flush=1 SHALL force the next state to IDLE from any state; done SHALL NOT pulse for an aborted operation, and result SHALL hold its previous value.
REQ-024 When flush and start are both high in IDLE, flush SHALL win and nothing SHALL be accepted.
REQ-025 result SHALL hold its value between done pulses; busy SHALL never be high in the same cycle as done.

Reset
REQ-026 reset=1 SHALL immediately set: state IDLE, result 0, done 0, busy 0, iteration counter 0, and internal registers 0.
REQ-027 Reset asserted mid-CALC SHALL abort the operation with no done pulse; the first start after deassertion SHALL be accepted normally.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/CALC/DONE) and the funct3 constants DIV_F3, DIVU_F3, REM_F3 and REMU_F3.
REQ-029 One combinational sub-module, div_step, SHALL perform a single restoring shift-subtract step (partial remainder, quotient bit); sign handling SHALL stay in divider_unit.

Verification
REQ-030 DIVU 100/7 SHALL give done after 33 cycles with result 14; REMU 100/7 SHALL give result 2.
REQ-031 DIV -7/2 SHALL give 0xFFFFFFFD (-3); REM -7/2 SHALL give 0xFFFFFFFF (-1); REM 7/-2 SHALL give 1.
REQ-032 DIV 5/0 SHALL give done one cycle after start with result 0xFFFFFFFF and busy never high; REMU 5/0 SHALL give 5.
REQ-033 DIV 0x80000000/0xFFFFFFFF SHALL give result 0x80000000 in 1 cycle; REM of the same operands SHALL give 0.
REQ-034 Flush at CALC cycle 10 SHALL give IDLE with no done pulse and result unchanged; an immediately following DIVU 9/3 SHALL give 3.
REQ-035 Reset asserted mid-CALC SHALL drive all outputs to 0 asynchronously; a new start applied during CALC SHALL be ignored, checked by comparing the result against the original operands.

Source files
------------

// File: rtl/divider_unit_pkg.sv
// divider_unit_pkg: shared FSM state type and M-extension divide funct3 encodings.
package divider_unit_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [2:0] DIV_F3  = 3'b100;
  localparam logic [2:0] DIVU_F3 = 3'b101;
  localparam logic [2:0] REM_F3  = 3'b110;
  localparam logic [2:0] REMU_F3 = 3'b111;
endpackage

// File: rtl/divider_unit_div_step.sv
// div_step: one restoring shift-subtract step on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q
);
  logic [WIDTH:0] shifted, diff;
  // partial remainder stays below divisor, so the shifted value fits in WIDTH+1 bits
  always_comb begin
    shifted  = {rem, bit_in};
    diff     = shifted - {1'b0, divisor};
    q        = shifted >= {1'b0, divisor};
    rem_next = q ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/divider_unit.sv
// divider_unit: iterative restoring divider for RISC-V DIV/DIVU/REM/REMU, one bit per cycle.
module divider_unit
  import divider_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  state_t state, state_n;
  logic [5:0] count;
  logic [WIDTH-1:0] rem_r, quo_r, divisor_r, step_rem, mag_a, mag_b, q_fin, sp_result;
  logic op_rem, neg_q, neg_r, step_q, is_signed, accept, div_zero, overflow, special, last;
  assign is_signed = ~funct3[0];
  assign accept    = state == IDLE && start && funct3[2] && !flush;
  assign div_zero  = srcB == '0;
  assign overflow  = is_signed && srcA == MIN && srcB == '1;
  assign special   = div_zero || overflow;
  assign mag_a     = is_signed && srcA[WIDTH-1] ? -srcA : srcA;
  assign mag_b     = is_signed && srcB[WIDTH-1] ? -srcB : srcB;
  assign sp_result = div_zero ? (funct3[1] ? srcA : '1) : (funct3[1] ? '0 : MIN);
  assign last      = count == 6'(WIDTH - 1);
  assign q_fin     = {quo_r[WIDTH-2:0], step_q};
  assign busy      = state == CALC || (accept && !special);
  assign done      = state == DONE;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_r),
    .bit_in  (quo_r[WIDTH-1]),
    .divisor (divisor_r),
    .rem_next(step_rem),
    .q       (step_q)
  );
  always_comb begin
    state_n = state;
    state_n = flush ? IDLE :
              state == IDLE ? (accept ? (special ? DONE : CALC) : IDLE) :
              state == CALC ? (last ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // quo_r starts as the dividend and shifts quotient bits in from the right
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      divisor_r <= '0;
      op_rem    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      result    <= '0;
    end else if (accept) begin
      count     <= '0;
      rem_r     <= '0;
      quo_r     <= mag_a;
      divisor_r <= mag_b;
      op_rem    <= funct3[1];
      neg_q     <= is_signed && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
      neg_r     <= is_signed && srcA[WIDTH-1];
      if (special) result <= sp_result;
    end else if (state == CALC && !flush) begin
      count <= count + 6'd1;
      rem_r <= step_rem;
      quo_r <= q_fin;
      if (last) result <= op_rem ? (neg_r ? -step_rem : step_rem) : (neg_q ? -q_fin : q_fin);
    end
  end
endmodule

// File: tb/tb_divider_unit.sv
// tb_divider_unit: directed table, corner sequences and random ops against an arithmetic model.
module tb_divider_unit;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0, done, busy;
  logic [2:0] funct3 = 3'b000;
  logic [31:0] srcA = '0, srcB = '0, result;
  int n_checks = 0, n_fail = 0;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;
  vec_t vecs[10];

  divider_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .srcA(srcA),
    .srcB(srcB), .flush(flush), .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (f3[0]) begin
      sa = longint'(a);
      sb = longint'(b);
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    q = sa / sb;
    r = sa % sb;
    return f3[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
  endfunction

  // issue one op, wait (bounded) for done, check result/latency/busy behaviour
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cycles = 0;
    bit busy_bad = 0;
    @(negedge clk);
    start = 1'b1; funct3 = f3; srcA = a; srcB = b;
    #1 chk({name, " busy_at_start"}, {31'd0, busy}, {31'd0, lat != 1});
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < 100) begin
      if (!busy) busy_bad = 1;
      @(negedge clk);
      cycles++;
    end
    chk({name, " done_seen"}, {31'd0, done}, 32'd1);
    chk({name, " result"}, result, exp);
    chk({name, " latency"}, cycles, lat);
    chk({name, " busy_calc"}, {31'd0, busy_bad}, 32'd0);
    chk({name, " busy_in_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({name, " done_pulse"}, {31'd0, done}, 32'd0);
    chk({name, " result_hold"}, result, exp);
  endtask

  task automatic expect_quiet(input string name, input int n, input logic [31:0] exp);
    bit seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk({name, " no_done"}, {31'd0, seen}, 32'd0);
    chk({name, " result_kept"}, result, exp);
  endtask

  initial begin
    logic [2:0] f3;
    logic [31:0] a, b;
    vecs[0] = '{"divu_100_7",   3'b101, 32'd100, 32'd7, 32'd14, 33};
    vecs[1] = '{"remu_100_7",   3'b111, 32'd100, 32'd7, 32'd2, 33};
    vecs[2] = '{"div_m7_2",     3'b100, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33};
    vecs[3] = '{"rem_m7_2",     3'b110, -32'sd7, 32'd2, 32'hFFFF_FFFF, 33};
    vecs[4] = '{"rem_7_m2",     3'b110, 32'd7, -32'sd2, 32'd1, 33};
    vecs[5] = '{"div_5_0",      3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
    vecs[6] = '{"remu_5_0",     3'b111, 32'd5, 32'd0, 32'd5, 1};
    vecs[7] = '{"div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[8] = '{"rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1};
    vecs[9] = '{"divu_max_1",   3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33};

    #12;
    chk("reset result", result, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // start with funct3[2]=0 is not a divide
    @(negedge clk);
    start = 1'b1; funct3 = 3'b001; srcA = 32'd50; srcB = 32'd5;
    #1 chk("non_div busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    expect_quiet("non_div", 40, 32'hFFFF_FFFF);

    // flush beats start in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b101; srcA = 32'd50; srcB = 32'd5;
    #1 chk("flush_start busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    expect_quiet("flush_start", 40, 32'hFFFF_FFFF);

    // flush at CALC cycle 10, then an immediate DIVU 9/3
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; srcA = 32'd1000; srcB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush idle_busy", {31'd0, busy}, 32'd0);
    chk("flush idle_done", {31'd0, done}, 32'd0);
    chk("flush result", result, 32'hFFFF_FFFF);
    run_op("after_flush", 3'b101, 32'd9, 32'd3, 32'd3, 33);
    expect_quiet("after_flush", 5, 32'd3);

    // start during CALC is ignored: result reflects the original operands
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; srcA = 32'd100; srcB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; funct3 = 3'b100; srcA = 32'd1000; srcB = 32'd10;
    @(negedge clk);
    start = 1'b0;
    begin
      int c = 0;
      while (!done && c < 100) begin @(negedge clk); c++; end
      chk("ignore_start done_seen", {31'd0, done}, 32'd1);
      chk("ignore_start result", result, 32'd14);
    end
    expect_quiet("ignore_start", 40, 32'd14);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; srcA = 32'd77; srcB = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset result", result, 32'd0);
    chk("async_reset done", {31'd0, done}, 32'd0);
    chk("async_reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    expect_quiet("after_reset", 40, 32'd0);
    run_op("after_reset", 3'b110, -32'sd100, 32'd7, 32'hFFFF_FFFE, 33);

    // random ops against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      f3 = {1'b1, 2'($urandom_range(0, 3))};
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if (i == 7) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      run_op("random", f3, a, b, model(f3, a, b), model_lat(f3, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
